// File: rtl/layer_pingpong_buf_if.sv
// layer_pingpong_buf_if: producer write beats, consumer reads/release and status of the ping-pong activation store
interface layer_pingpong_buf_if #(
  parameter int MAC_CNT    = 32,
  parameter int DATA_WIDTH = 8,
  parameter int WR_BEATS   = 2,
  parameter int ADDR_WIDTH = $clog2(MAC_CNT*WR_BEATS)
);
  logic                          clear_i;
  logic                          wr_en_i;
  logic [MAC_CNT*DATA_WIDTH-1:0] data_i;
  logic                          wr_ready_o;
  logic                          fill_done_o;
  logic                          rd_avail_o;
  logic                          rd_en_i;
  logic [ADDR_WIDTH-1:0]         rd_addr_i;
  logic [DATA_WIDTH-1:0]         rd_data_o;
  logic                          rd_valid_o;
  logic                          rd_release_i;
  logic                          ovf_o;
  logic [1:0]                    bank_cnt_o;
  modport master (
    output clear_i, wr_en_i, data_i, rd_en_i, rd_addr_i, rd_release_i,
    input  wr_ready_o, fill_done_o, rd_avail_o, rd_data_o, rd_valid_o, ovf_o, bank_cnt_o
  );
  modport slave (
    input  clear_i, wr_en_i, data_i, rd_en_i, rd_addr_i, rd_release_i,
    output wr_ready_o, fill_done_o, rd_avail_o, rd_data_o, rd_valid_o, ovf_o, bank_cnt_o
  );
endinterface

// File: rtl/layer_pingpong_buf.sv
// layer_pingpong_buf: two-bank activation store, wide beats in from one layer, byte reads out to the next
module layer_pingpong_buf #(
  parameter int MAC_CNT    = 32,
  parameter int DATA_WIDTH = 8,
  parameter int WR_BEATS   = 2,
  parameter int ADDR_WIDTH = $clog2(MAC_CNT*WR_BEATS)
) (
  input logic                   clk_i,
  input logic                   rstn_i,
  layer_pingpong_buf_if.slave   bus
);
  localparam int DEPTH = MAC_CNT*WR_BEATS;
  localparam int IW    = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int BW    = WR_BEATS > 1 ? $clog2(WR_BEATS) : 1;
  logic                  wbank, rbank;
  logic [BW-1:0]         beat;
  logic [1:0]            full_cnt;
  logic                  fill_done, rd_valid, ovf;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] mem [2][DEPTH];
  logic                  wr_ready, rd_avail, wr_acc, last, rel, rd_acc, in_range;
  logic [IW-1:0]         rd_idx;
  always_comb begin
    wr_ready = full_cnt != 2'd2;
    rd_avail = full_cnt != 2'd0;
    wr_acc   = bus.wr_en_i & wr_ready;
    last     = wr_acc & (beat == BW'(WR_BEATS-1));
    rel      = bus.rd_release_i & rd_avail;
    rd_acc   = bus.rd_en_i & rd_avail;
    in_range = int'(bus.rd_addr_i) < DEPTH;
    rd_idx   = bus.rd_addr_i[IW-1:0];
  end
  // storage has no reset; a write is suppressed while held in reset or flushed
  always_ff @(posedge clk_i)
    if (wr_acc & rstn_i & !bus.clear_i)
      for (int k = 0; k < MAC_CNT; k++)
        mem[wbank][IW'(int'(beat)*MAC_CNT + k)] <= bus.data_i[k*DATA_WIDTH +: DATA_WIDTH];
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i || bus.clear_i) begin
      wbank     <= 1'b0;
      rbank     <= 1'b0;
      beat      <= '0;
      full_cnt  <= 2'd0;
      fill_done <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      ovf       <= 1'b0;
    end else begin
      wbank     <= wbank ^ last;
      rbank     <= rbank ^ rel;
      beat      <= last ? '0 : wr_acc ? beat + BW'(1) : beat;
      full_cnt  <= full_cnt + {1'b0, last} - {1'b0, rel};
      fill_done <= last;
      rd_valid  <= rd_acc;
      rd_data   <= rd_acc & in_range ? mem[rbank][rd_idx] : '0;
      ovf       <= ovf | (bus.wr_en_i & !wr_ready);
    end
  assign bus.wr_ready_o  = wr_ready;
  assign bus.fill_done_o = fill_done;
  assign bus.rd_avail_o  = rd_avail;
  assign bus.rd_data_o   = rd_data;
  assign bus.rd_valid_o  = rd_valid;
  assign bus.ovf_o       = ovf;
  assign bus.bank_cnt_o  = full_cnt;
endmodule

// File: tb/tb_layer_pingpong_buf.sv
// tb_layer_pingpong_buf: directed stimulus with a read-data scoreboard checked by an independent monitor
module tb_layer_pingpong_buf;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  always #5 clk = ~clk;
  layer_pingpong_buf_if #(.MAC_CNT(4), .DATA_WIDTH(8), .WR_BEATS(2), .ADDR_WIDTH(4)) bus();
  layer_pingpong_buf #(.MAC_CNT(4), .DATA_WIDTH(8), .WR_BEATS(2), .ADDR_WIDTH(4)) dut (
    .clk_i(clk), .rstn_i(rstn), .bus(bus)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (rstn && bus.rd_valid_o) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rd_valid: got data %h expected no read", bus.rd_data_o);
      end else check("rd_data", {24'h0, bus.rd_data_o}, {24'h0, exp_q.pop_front()});
    end
  task automatic tick();
    @(negedge clk);
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
    bus.rd_release_i = 1'b0;
    bus.clear_i = 1'b0;
  endtask
  task automatic wr_set(input logic [31:0] d);
    bus.wr_en_i = 1'b1;
    bus.data_i = d;
  endtask
  task automatic rd_set(input logic [3:0] a, input logic [7:0] e);
    bus.rd_en_i = 1'b1;
    bus.rd_addr_i = a;
    exp_q.push_back(e);
  endtask
  task automatic wr(input logic [31:0] d);
    wr_set(d);
    tick();
  endtask
  task automatic rd(input logic [3:0] a, input logic [7:0] e);
    rd_set(a, e);
    tick();
  endtask
  task automatic status(input string tag, input logic [1:0] cnt, input logic fd, input logic ov);
    check({tag, "_bank_cnt"}, {30'h0, bus.bank_cnt_o}, {30'h0, cnt});
    check({tag, "_fill_done"}, {31'h0, bus.fill_done_o}, {31'h0, fd});
    check({tag, "_ovf"}, {31'h0, bus.ovf_o}, {31'h0, ov});
    check({tag, "_wr_ready"}, {31'h0, bus.wr_ready_o}, {31'h0, cnt != 2'd2});
    check({tag, "_rd_avail"}, {31'h0, bus.rd_avail_o}, {31'h0, cnt != 2'd0});
  endtask
  initial begin
    bus.clear_i = 1'b0;
    bus.wr_en_i = 1'b0;
    bus.data_i = '0;
    bus.rd_en_i = 1'b0;
    bus.rd_addr_i = '0;
    bus.rd_release_i = 1'b0;
    repeat (2) @(negedge clk);
    status("reset", 2'd0, 1'b0, 1'b0);
    check("reset_rd_valid", {31'h0, bus.rd_valid_o}, 32'h0);
    check("reset_rd_data", {24'h0, bus.rd_data_o}, 32'h0);
    rstn = 1'b1;
    tick();
    // first bank fill, reads starting in the fill_done cycle
    wr(32'h04030201);
    status("beat1", 2'd0, 1'b0, 1'b0);
    wr(32'h08070605);
    status("fill0", 2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) rd(4'(i), 8'(i + 1));
    check("fill_done_pulse", {31'h0, bus.fill_done_o}, 32'h0);
    rd(4'd9, 8'h00);
    // final beat with release; the same-cycle read still sees the old bank
    wr(32'h0c0b0a09);
    wr_set(32'h100f0e0d);
    bus.rd_release_i = 1'b1;
    rd_set(4'd2, 8'h03);
    tick();
    status("fill_rel", 2'd1, 1'b1, 1'b0);
    rd(4'd0, 8'h09);
    rd(4'd3, 8'h0c);
    rd(4'd7, 8'h10);
    // both banks full, release collides with a rejected write
    wr(32'h14131211);
    wr(32'h18171615);
    status("full2", 2'd2, 1'b1, 1'b0);
    wr_set(32'h55555555);
    bus.rd_release_i = 1'b1;
    tick();
    status("rel_rej", 2'd1, 1'b0, 1'b1);
    wr(32'h1c1b1a19);
    status("refill_b1", 2'd1, 1'b0, 1'b1);
    wr(32'h201f1e1d);
    status("refill_b2", 2'd2, 1'b1, 1'b1);
    wr(32'hdeadbeef);
    status("overrun", 2'd2, 1'b0, 1'b1);
    rd(4'd0, 8'h11);
    rd(4'd3, 8'h14);
    rd(4'd7, 8'h18);
    bus.rd_release_i = 1'b1;
    tick();
    rd(4'd0, 8'h19);
    rd(4'd7, 8'h20);
    bus.rd_release_i = 1'b1;
    tick();
    bus.rd_release_i = 1'b1;
    tick();
    status("empty_rel", 2'd0, 1'b0, 1'b1);
    bus.rd_en_i = 1'b1;
    bus.rd_addr_i = 4'd0;
    tick();
    check("empty_rd_valid", {31'h0, bus.rd_valid_o}, 32'h0);
    check("empty_rd_data", {24'h0, bus.rd_data_o}, 32'h0);
    // flush wins over a completing beat
    wr(32'h33333333);
    wr_set(32'h77777777);
    bus.clear_i = 1'b1;
    tick();
    status("clear", 2'd0, 1'b0, 1'b0);
    // asynchronous reset in the middle of a fill
    wr(32'h44332211);
    wr(32'h88776655);
    rd_set(4'd1, 8'h22);
    wr_set(32'haaaaaaaa);
    tick();
    check("pre_rst_rd_valid", {31'h0, bus.rd_valid_o}, 32'h1);
    #2 rstn = 1'b0;
    #1;
    status("async_rst", 2'd0, 1'b0, 1'b0);
    check("async_rd_valid", {31'h0, bus.rd_valid_o}, 32'h0);
    check("async_rd_data", {24'h0, bus.rd_data_o}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    wr(32'hd4c3b2a1);
    status("post_rst_b1", 2'd0, 1'b0, 1'b0);
    wr(32'hd8c7b6a5);
    status("post_rst_b2", 2'd1, 1'b1, 1'b0);
    rd(4'd0, 8'ha1);
    rd(4'd4, 8'ha5);
    tick();
    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
